// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   PC_W        : program counter / address width
//   INSTR_W     : instruction word width
//   INSTR_BYTES : bytes per instruction (PC increment)
//   ST_*        : fetch state encodings, also exposed as ifu_state_e
// ---------------------------------------------------------------------------
package ifu_pkg;

  localparam int PC_W        = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    FULL  = ST_FULL,
    FAULT = ST_FAULT
  } ifu_state_e;

endpackage

// File: rtl/fetch_wait_counter.sv
// ---------------------------------------------------------------------------
// fetch_wait_counter
// Counts cycles the fetch address has been stable. Clears on srst or clear,
// increments while en is high, saturates at MAX.
//   clk     : clock
//   srst    : synchronous active-high reset
//   clear   : address changes this cycle, restart the count
//   en      : count enable
//   data_ok : memory data is valid for the current address
//             (count >= MAX-1, i.e. MAX cycles of stable address)
// ---------------------------------------------------------------------------
module fetch_wait_counter #(
  parameter int MAX = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic en,
  output logic data_ok
);

  localparam int CNT_W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] SAT   = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] OK_AT = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != SAT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // The cycle that sees count MAX-1 is the MAX-th cycle with a stable address.
  assign data_ok = (cnt_reg >= OK_AT);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Requester side of the instruction memory interface. Owns the PC, waits out
// the memory read latency, captures the instruction word and hands it to
// decode with a valid/ready handshake. Accepts PC redirects from branches.
//
// Ports:
//   CLK        in   clock
//   Reset      in   synchronous active-high reset
//   Address    out  instruction memory address (registered PC)
//   Data       in   instruction word from memory
//   Instr      out  captured instruction
//   InstrPC    out  address Instr was fetched from
//   InstrValid out  Instr/InstrPC valid
//   InstrReady in   decode accepts Instr this cycle
//   Redirect   in   load RedirectPC and drop any pending/held fetch
//   RedirectPC in   redirect target
//   Fault      out  sticky bounds/alignment fault
//
// Build option: define IFU_BOUNDS_CHECK_EN to enable the bounds/alignment
// check and the FAULT state. Without it Fault is tied low and the PC wraps
// freely with its low bits untouched.
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 64'h0,
  parameter int              RD_WAIT   = 2,
  parameter int              MEM_BYTES = 160
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic [PC_W-1:0]    Address,
  input  logic [INSTR_W-1:0] Data,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    InstrPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectPC,
  output logic               Fault
);

`ifdef IFU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [PC_W-1:0]    pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [PC_W-1:0]    instr_pc_reg;
  ifu_state_e         state_reg;

  logic data_ok;
  logic valid;
  logic in_fault;
  logic transfer;
  logic would_load;
  logic pc_bad;
  logic fault_entry;
  logic load;
  logic redirect_take;

  assign valid    = (state_reg == FULL);
  assign in_fault = BOUNDS_EN && (state_reg == FAULT);
  assign transfer = valid && InstrReady;

  // A fetch can complete when data has settled and the output slot is free
  // or being emptied this cycle.
  assign would_load = data_ok && (!valid || InstrReady) && !in_fault;

  assign pc_bad = (pc_reg[1:0] != 2'b00) || (pc_reg >= PC_W'(MEM_BYTES));

  // Fault entry outranks a same-cycle Redirect, so a bad PC cannot be
  // escaped by redirecting on the very cycle its fetch completes.
  assign fault_entry   = BOUNDS_EN && would_load && pc_bad;
  assign redirect_take = Redirect && !in_fault && !fault_entry;
  assign load          = would_load && !Redirect && !fault_entry;

  fetch_wait_counter #(
    .MAX (RD_WAIT)
  ) u_wait (
    .clk     (CLK),
    .srst    (Reset),
    .clear   (load || redirect_take),
    .en      (1'b1),
    .data_ok (data_ok)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      state_reg    <= EMPTY;
    end else if (fault_entry) begin
      // PC frozen, held instruction discarded.
      state_reg <= FAULT;
    end else if (in_fault) begin
      state_reg <= FAULT;
    end else if (redirect_take) begin
      // A same-cycle transfer has already been consumed by decode; anything
      // not transferred is simply dropped.
      pc_reg    <= RedirectPC;
      state_reg <= EMPTY;
    end else if (load) begin
      instr_reg    <= Data;
      instr_pc_reg <= pc_reg;
      pc_reg       <= pc_reg + PC_W'(INSTR_BYTES);
      state_reg    <= FULL;
    end else if (transfer) begin
      state_reg <= EMPTY;
    end
  end

  assign Address    = pc_reg;
  assign Instr      = instr_reg;
  assign InstrPC    = instr_pc_reg;
  assign InstrValid = valid;
  assign Fault      = in_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. Instance a: RESET_PC=0,
// RD_WAIT=2. Instance b: RESET_PC=...FFFC, RD_WAIT=1 (wrap case).
// The instruction memory is a fixed lookup on Address.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a
  logic        rst_a, rdy_a, redir_a, valid_a, fault_a;
  logic [63:0] rpc_a, addr_a, ipc_a;
  logic [31:0] data_a, instr_a;
  // instance b
  logic        rst_b, rdy_b, redir_b, valid_b, fault_b;
  logic [63:0] rpc_b, addr_b, ipc_b;
  logic [31:0] data_b, instr_b;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Standard test program 1; out-of-range or unaligned reads return a tag.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a >= 64'd160 || a[1:0] != 2'b00) return {16'hDEAD, a[15:0]};
    case (a[7:2])
      6'd0:    return 32'hF84003E9;
      6'd1:    return 32'hF84083EA;
      6'd2:    return 32'hF84103EB;
      6'd3:    return 32'hF84183EC;
      6'd4:    return 32'hF84203ED;
      6'd5:    return 32'hF84283EE;
      6'd6:    return 32'hF84303EF;
      6'd7:    return 32'hB4000100;
      6'd8:    return 32'h8B0901AD;
      6'd9:    return 32'h8B0A01CE;
      6'd10:   return 32'hCB0B01EF;
      6'd11:   return 32'hD503201F;
      6'd12:   return 32'h17FFFFF4;
      default: return 32'h00000000;
    endcase
  endfunction

  assign data_a = mem_word(addr_a);
  assign data_b = mem_word(addr_b);

  instruction_fetch_unit #(
    .RESET_PC (64'h0), .RD_WAIT (2), .MEM_BYTES (160)
  ) u_dut_a (
    .CLK (clk), .Reset (rst_a), .Address (addr_a), .Data (data_a),
    .Instr (instr_a), .InstrPC (ipc_a), .InstrValid (valid_a),
    .InstrReady (rdy_a), .Redirect (redir_a), .RedirectPC (rpc_a),
    .Fault (fault_a)
  );

  instruction_fetch_unit #(
    .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC), .RD_WAIT (1), .MEM_BYTES (160)
  ) u_dut_b (
    .CLK (clk), .Reset (rst_b), .Address (addr_b), .Data (data_b),
    .Instr (instr_b), .InstrPC (ipc_b), .InstrValid (valid_b),
    .InstrReady (rdy_b), .Redirect (redir_b), .RedirectPC (rpc_b),
    .Fault (fault_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [63:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [63:0] exp_ipc;
    logic [63:0] exp_addr;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic setv(input int i, input logic rst, input logic rdy, input logic redir,
                      input logic [63:0] rpc, input logic v, input logic [31:0] ins,
                      input logic [63:0] ipc, input logic [63:0] adr);
    vecs[i] = '{rst, rdy, redir, rpc, v, ins, ipc, adr};
  endtask

  initial begin
    // each row: inputs for the next edge, expected outputs after it
    // test 1: reset, first fetches (RD_WAIT=2)
    setv( 0, 1, 1, 0, 64'h0,  0, 32'h0,        64'h0,  64'h0);
    setv( 1, 0, 1, 0, 64'h0,  0, 32'h0,        64'h0,  64'h0);
    setv( 2, 0, 1, 0, 64'h0,  1, 32'hF84003E9, 64'h0,  64'h4);
    setv( 3, 0, 1, 0, 64'h0,  0, 32'hF84003E9, 64'h0,  64'h4);
    setv( 4, 0, 1, 0, 64'h0,  1, 32'hF84083EA, 64'h4,  64'h8);
    setv( 5, 0, 1, 0, 64'h0,  0, 32'hF84083EA, 64'h4,  64'h8);
    setv( 6, 0, 1, 0, 64'h0,  1, 32'hF84103EB, 64'h8,  64'hC);
    // test 2: stall 5 cycles, then back-to-back load on release
    setv( 7, 0, 0, 0, 64'h0,  1, 32'hF84103EB, 64'h8,  64'hC);
    setv( 8, 0, 0, 0, 64'h0,  1, 32'hF84103EB, 64'h8,  64'hC);
    setv( 9, 0, 0, 0, 64'h0,  1, 32'hF84103EB, 64'h8,  64'hC);
    setv(10, 0, 0, 0, 64'h0,  1, 32'hF84103EB, 64'h8,  64'hC);
    setv(11, 0, 0, 0, 64'h0,  1, 32'hF84103EB, 64'h8,  64'hC);
    setv(12, 0, 1, 0, 64'h0,  1, 32'hF84183EC, 64'hC,  64'h10);
    setv(13, 0, 1, 0, 64'h0,  0, 32'hF84183EC, 64'hC,  64'h10);
    setv(14, 0, 1, 0, 64'h0,  1, 32'hF84203ED, 64'h10, 64'h14);
    setv(15, 0, 1, 0, 64'h0,  0, 32'hF84203ED, 64'h10, 64'h14);
    // test 3: redirect while FULL at 0x14, not accepted
    setv(16, 0, 0, 0, 64'h0,  1, 32'hF84283EE, 64'h14, 64'h18);
    setv(17, 0, 0, 1, 64'h20, 0, 32'hF84283EE, 64'h14, 64'h20);
    setv(18, 0, 1, 0, 64'h0,  0, 32'hF84283EE, 64'h14, 64'h20);
    setv(19, 0, 1, 0, 64'h0,  1, 32'h8B0901AD, 64'h20, 64'h24);
    // test 4: reset beats redirect; redirect beats load
    setv(20, 1, 1, 1, 64'h2C, 0, 32'h0,        64'h0,  64'h0);
    setv(21, 0, 1, 0, 64'h0,  0, 32'h0,        64'h0,  64'h0);
    setv(22, 0, 1, 1, 64'h2C, 0, 32'h0,        64'h0,  64'h2C);
    setv(23, 0, 1, 0, 64'h0,  0, 32'h0,        64'h0,  64'h2C);
    setv(24, 0, 1, 0, 64'h0,  1, 32'hD503201F, 64'h2C, 64'h30);
    setv(25, 0, 1, 0, 64'h0,  0, 32'hD503201F, 64'h2C, 64'h30);
    setv(26, 0, 1, 0, 64'h0,  1, 32'h17FFFFF4, 64'h30, 64'h34);

    rst_a = 1'b1; rdy_a = 1'b0; redir_a = 1'b0; rpc_a = 64'h0;
    rst_b = 1'b1; rdy_b = 1'b0; redir_b = 1'b0; rpc_b = 64'h0;
    step();
    step();

    for (int i = 0; i < NV; i++) begin
      rst_a   = vecs[i].rst;
      rdy_a   = vecs[i].rdy;
      redir_a = vecs[i].redir;
      rpc_a   = vecs[i].rpc;
      step();
      $display("vec %0d: addr=%h valid=%b instr=%h pc=%h fault=%b",
               i, addr_a, valid_a, instr_a, ipc_a, fault_a);
      chk($sformatf("v%0d InstrValid", i), {63'h0, valid_a}, {63'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d Instr", i), {32'h0, instr_a}, {32'h0, vecs[i].exp_instr});
      chk($sformatf("v%0d InstrPC", i), ipc_a, vecs[i].exp_ipc);
      chk($sformatf("v%0d Address", i), addr_a, vecs[i].exp_addr);
      chk($sformatf("v%0d Fault", i), {63'h0, fault_a}, 64'h0);
    end
    redir_a = 1'b0;

    // test 5: misaligned redirect
    rdy_a = 1'b1; redir_a = 1'b1; rpc_a = 64'h22;
    step();
    redir_a = 1'b0;
    chk("t5 redirect addr", addr_a, 64'h22);
    chk("t5 redirect valid", {63'h0, valid_a}, 64'h0);
    step();
    step();
    $display("t5 unaligned fetch: addr=%h valid=%b instr=%h fault=%b", addr_a, valid_a, instr_a, fault_a);
`ifdef IFU_BOUNDS_CHECK_EN
    chk("t5 fault set", {63'h0, fault_a}, 64'h1);
    chk("t5 fault valid", {63'h0, valid_a}, 64'h0);
    chk("t5 fault addr frozen", addr_a, 64'h22);
    redir_a = 1'b1; rpc_a = 64'h8;
    step();
    step();
    redir_a = 1'b0;
    step();
    chk("t5 redirect ignored addr", addr_a, 64'h22);
    chk("t5 still faulted", {63'h0, fault_a}, 64'h1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("t5 reset clears fault", {63'h0, fault_a}, 64'h0);
    chk("t5 reset addr", addr_a, 64'h0);
    step();
    step();
    chk("t5 resume pc", ipc_a, 64'h0);
    chk("t5 resume valid", {63'h0, valid_a}, 64'h1);
    redir_a = 1'b1; rpc_a = 64'hA0;
    step();
    redir_a = 1'b0;
    step();
    step();
    chk("t5 oob fault", {63'h0, fault_a}, 64'h1);
    chk("t5 oob addr", addr_a, 64'hA0);
`else
    chk("t5 no fault", {63'h0, fault_a}, 64'h0);
    chk("t5 unaligned valid", {63'h0, valid_a}, 64'h1);
    chk("t5 unaligned pc", ipc_a, 64'h22);
    chk("t5 unaligned instr", {32'h0, instr_a}, {32'h0, mem_word(64'h22)});
    chk("t5 unaligned next addr", addr_a, 64'h26);
`endif

    // test 6: RD_WAIT=1 wrap from ...FFFC, one instruction per cycle
    rdy_b = 1'b1;
    chk("t6 reset addr", addr_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6 reset valid", {63'h0, valid_b}, 64'h0);
    rst_b = 1'b0;
    step();
    $display("t6 cyc0: addr=%h valid=%b instr=%h pc=%h", addr_b, valid_b, instr_b, ipc_b);
    chk("t6 c0 pc", ipc_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6 c0 valid", {63'h0, valid_b}, 64'h1);
    chk("t6 c0 addr wrap", addr_b, 64'h0);
    step();
    $display("t6 cyc1: addr=%h valid=%b instr=%h pc=%h", addr_b, valid_b, instr_b, ipc_b);
    chk("t6 c1 pc", ipc_b, 64'h0);
    chk("t6 c1 instr", {32'h0, instr_b}, 64'hF84003E9);
    chk("t6 c1 valid", {63'h0, valid_b}, 64'h1);
    step();
    $display("t6 cyc2: addr=%h valid=%b instr=%h pc=%h", addr_b, valid_b, instr_b, ipc_b);
    chk("t6 c2 pc", ipc_b, 64'h4);
    chk("t6 c2 instr", {32'h0, instr_b}, 64'hF84083EA);
    chk("t6 fault", {63'h0, fault_b}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
